alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have the parameter W, default 17, which sets the operand width in bits; all widths below are for W=17.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request strobe; sampled only in IDLE.
REQ-005 opcode  in  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
REQ-006 op_a  in  17  operand A, latched on the accepted start.
REQ-007 op_b  in  17  operand B, latched on the accepted start.
REQ-008 busy  out  1  high from the cycle after start is accepted until done.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 err  out  1  valid with done; high when the opcode was reserved.
REQ-011 result  out  34  registered result; it SHALL hold its value until the next done.
REQ-012 dp_op_a  out  17  A operand driven to the shared add/sub datapath.
REQ-013 dp_op_b  out  17  B operand driven to the shared add/sub datapath.
REQ-014 dp_op  out  1  datapath subtract select; the datapath inverts A when dp_op is high.
REQ-015 dp_mult_mode  out  1  datapath add/sub-versus-mult mode select.
REQ-016 dp_cin  out  1  datapath carry-in.
REQ-017 dp_sum  in  17  datapath sum, combinational from the dp_* outputs.
REQ-018 dp_cout  in  1  datapath carry-out.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ADDSUB, MUL and DONE.
REQ-020 In IDLE, start=1 SHALL latch op_a, op_b and opcode. The next state SHALL be ADDSUB for opcode 00, 01 or 11, and MUL for opcode 10.
REQ-021 start SHALL be ignored in every state other than IDLE; no queuing, and latched operands SHALL NOT change.
REQ-022 ADDSUB SHALL last one cycle.
  - ADD: dp_op=0, dp_cin=0.
  - SUB: dp_op=1, dp_cin=1, so the datapath computes B-A mod 2^17.
  - In both cases dp_mult_mode=0, dp_op_a=A, dp_op_b=B.
REQ-023 At the end of ADDSUB, result SHALL be loaded with {16'b0, dp_cout, dp_sum}. For SUB, dp_cout=1 means no borrow (B>=A).
REQ-024 Opcode 11 SHALL pass through ADDSUB with every dp_* output at 0. It SHALL load result=0 and produce err=1 with done.
REQ-025 MUL SHALL be unsigned 17x17 shift-add using a 17-bit accumulator high half ACC and a multiplier register Q, initialised ACC=0 and Q=B.
REQ-026 In each MUL cycle the datapath SHALL be driven as follows:
  - dp_op=0, dp_cin=0, dp_mult_mode=1.
  - dp_op_b=ACC.
  - dp_op_a=A when Q[0]=1, else 0.
REQ-027 At the end of each MUL cycle, {ACC, Q} SHALL load {dp_cout, dp_sum, Q[16:1]}, i.e. a right shift of the 35-bit value {cout, sum, Q}.
REQ-028 A 5-bit iteration counter SHALL run 0..16. MUL SHALL last exactly 17 cycles, and the final cycle SHALL load result={ACC, Q} with the updated values.
REQ-029 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
  - start is not accepted in DONE.
  - Minimum start-to-start spacing: ADD/SUB 3 cycles, MUL 19 cycles.
REQ-030 Latency, counted from the start-accepting edge:
  - ADD/SUB: done is high in the 2nd cycle.
  - MUL: done is high in the 18th cycle.
REQ-031 In IDLE and DONE, all dp_* outputs SHALL be 0.
REQ-032 err SHALL be 0 whenever done=0.
REQ-033 The counter SHALL NOT wrap within an operation; its value SHALL be don't-care outside MUL.
REQ-034 When opcode changes while busy, the operation in flight SHALL be unaffected.
REQ-035 Operand extremes (0, 17'h1FFFF) SHALL NOT need special-case logic: the 34-bit product and the 18-bit add result cannot overflow result.

Reset
REQ-036 rst_n=0 SHALL force IDLE immediately, regardless of clk, and SHALL clear all of the following to 0:
  - busy, done, err and result;
  - ACC, Q and the counter;
  - the latched operands and all dp_* outputs.
REQ-037 Reset asserted mid-operation SHALL abort the operation with no done pulse. After release, the first accepted start SHALL behave as from power-up.
REQ-038 Release of rst_n SHALL take effect on the next rising edge; a start sampled on that edge SHALL be accepted.

Verification
REQ-039 ADD, A=17'h0FFFF, B=17'h00001 -> done at cycle 2, result=34'h000010000, err=0.
REQ-040 SUB, A=3, B=5 -> result=34'h000020002; then SUB, A=5, B=3 -> result=34'h00001FFFE.
REQ-041 MUL, A=B=17'h1FFFF -> busy for 17 cycles, done at cycle 18, result=34'h3FFFC0001, dp_mult_mode=1 throughout MUL.
REQ-042 MUL with A=0 or B=0 -> result=0. MUL with A=1, B=17'h12345 -> result=34'h000012345.
REQ-043 start pulsed during MUL with different operands -> ignored; result and timing unchanged. Opcode 11 -> done with err=1 and result=0.
REQ-044 rst_n pulsed low at MUL iteration 8 -> no done pulse, all outputs 0; a subsequent ADD 2+2 -> result=4 at cycle 2.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencer for a shared add/sub datapath.
// Runs ADD/SUB in one pass and MUL as 17-step shift-add.
module alu_seq_ctrl #(
  parameter int W = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     opcode,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   dp_op_a,
  output logic [W-1:0]   dp_op_b,
  output logic           dp_op,
  output logic           dp_mult_mode,
  output logic           dp_cin,
  input  logic [W-1:0]   dp_sum,
  input  logic           dp_cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDSUB,
    S_MUL,
    S_DONE
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(W - 1);
  localparam logic [1:0] OP_MUL   = 2'b10;
  localparam logic [1:0] OP_RSV   = 2'b11;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [1:0]       opc_q, opc_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     q_q, q_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [2*W-1:0]   res_q, res_d;
  logic             err_q, err_d;

  assign busy   = (state_q == S_ADDSUB) || (state_q == S_MUL);
  assign done   = (state_q == S_DONE);
  assign err    = done & err_q;
  assign result = res_q;

  // Datapath drive: decoded purely from state and latched operands.
  always_comb begin
    dp_op_a      = '0;
    dp_op_b      = '0;
    dp_op        = 1'b0;
    dp_mult_mode = 1'b0;
    dp_cin       = 1'b0;
    unique case (state_q)
      S_ADDSUB: begin
        if (opc_q != OP_RSV) begin
          dp_op_a = a_q;
          dp_op_b = b_q;
          dp_op   = opc_q[0];
          dp_cin  = opc_q[0];
        end
      end
      S_MUL: begin
        dp_mult_mode = 1'b1;
        dp_op_b      = acc_q;
        dp_op_a      = q_q[0] ? a_q : '0;
      end
      default: ;
    endcase
  end

  // Next-state, operand latch, multiply step and result load.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    opc_d   = opc_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          opc_d   = opcode;
          acc_d   = '0;
          q_d     = op_b;
          cnt_d   = '0;
          state_d = (opcode == OP_MUL) ? S_MUL : S_ADDSUB;
        end
      end
      S_ADDSUB: begin
        if (opc_q == OP_RSV) begin
          res_d = '0;
          err_d = 1'b1;
        end else begin
          res_d = {{(W-1){1'b0}}, dp_cout, dp_sum};
          err_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_MUL: begin
        {acc_d, q_d} = {dp_cout, dp_sum, q_q[W-1:1]};
        cnt_d        = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          res_d   = {dp_cout, dp_sum, q_q[W-1:1]};
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opc_q   <= opc_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule
